// File: rtl/mem_writeback_pkg.sv
// Opcode and state encodings for the memory/writeback stage, kept here so that
// the decode and execute stages can share them.
package mem_writeback_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MOV = 5'b00010;
    localparam logic [4:0] OP_MVI = 5'b00011;
    localparam logic [4:0] OP_STA = 5'b00100;
    localparam logic [4:0] OP_LDA = 5'b00101;
    localparam logic [4:0] OP_JZ  = 5'b00110;
    localparam logic [4:0] OP_JMP = 5'b00111;
    localparam logic [4:0] OP_IN  = 5'b01000;
    localparam logic [4:0] OP_OUT = 5'b01001;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEM    = 2'd1;
    localparam logic [1:0] ST_INWAIT = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    // State entered from IDLE when an instruction with this opcode is accepted.
    function automatic logic [1:0] first_state(input logic [4:0] op);
        if (op == OP_STA || op == OP_LDA) begin
            return ST_MEM;
        end else if (op == OP_IN) begin
            return ST_INWAIT;
        end
        return ST_WB;
    endfunction

    function automatic logic writes_alu_result(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV) || (op == OP_MVI);
    endfunction

endpackage

// File: rtl/mem_writeback.sv
// Memory-access / writeback stage: accepts one instruction from execute, performs
// an optional memory or input-port wait, then issues a single-cycle writeback.
module mem_writeback
    import mem_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] IR,
    input  logic [7:0]  ALUOUT,
    input  logic [15:0] Addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        pc_load,
    output logic [15:0] pc_target,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  rd_q, rd_d;
    logic [7:0]  alu_q, alu_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  out_data_q, out_data_d;

    logic in_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            addr_q     <= '0;
            cap_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            addr_q     <= addr_d;
            cap_q      <= cap_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        addr_d     = addr_q;
        cap_d      = cap_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = IR[15:11];
                    rd_d    = IR[10:8];
                    alu_d   = ALUOUT;
                    addr_d  = Addr;
                    state_d = first_state(IR[15:11]);
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_LDA) begin
                        cap_d = mem_rdata;
                    end
                    state_d = ST_WB;
                end
            end
            ST_INWAIT: begin
                if (in_valid) begin
                    cap_d   = in_data;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (op_q == OP_OUT) begin
                    out_data_d = alu_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs decode from registered state, so async reset zeroes them at once.
    assign in_wb     = (state_q == ST_WB);
    assign busy      = (state_q != ST_IDLE);
    assign done      = in_wb;

    assign mem_req   = (state_q == ST_MEM);
    assign mem_we    = mem_req && (op_q == OP_STA);
    assign mem_addr  = mem_req ? addr_q : 16'h0000;
    assign mem_wdata = mem_we ? alu_q : 8'h00;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 3'd0;
        rf_wdata = 8'h00;
        if (in_wb) begin
            if (writes_alu_result(op_q)) begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_q;
            end else if (op_q == OP_LDA || op_q == OP_IN) begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = cap_q;
            end
        end
    end

    assign pc_load   = in_wb && ((op_q == OP_JMP) || (op_q == OP_JZ && alu_q == 8'h00));
    assign pc_target = pc_load ? addr_q : 16'h0000;

    // out_data shows the new value during the out_valid cycle, then holds it.
    assign out_valid = in_wb && (op_q == OP_OUT);
    assign out_data  = out_valid ? alu_q : out_data_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: inputs driven and outputs checked on the falling edge.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] IR;
    logic [7:0]  ALUOUT;
    logic [15:0] Addr;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    mem_writeback dut (
        .clk(clk), .rst(rst), .start(start), .IR(IR), .ALUOUT(ALUOUT), .Addr(Addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .in_data(in_data), .in_valid(in_valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_load(pc_load), .pc_target(pc_target), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ir, input logic [7:0] alu, input logic [15:0] ad);
        start  = 1'b1;
        IR     = ir;
        ALUOUT = alu;
        Addr   = ad;
        step();
        start  = 1'b0;
        IR     = 16'h0000;
        ALUOUT = 8'h00;
        Addr   = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; IR = '0; ALUOUT = '0; Addr = '0;
        mem_rdata = '0; mem_ack = 1'b0; in_data = '0; in_valid = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_rf_we", rf_we, 0);
        step();
        rst = 1'b0;
        step();
        $display("reset released: busy=%0b", busy);
        chk("idle_busy", busy, 0);

        // ADD rd=3, 5A
        issue(16'h0300, 8'h5A, 16'h0000);
        $display("ADD: rf_we=%0b waddr=%0d wdata=%0h done=%0b", rf_we, rf_waddr, rf_wdata, done);
        chk("add_rf_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 3);
        chk("add_wdata", rf_wdata, 8'h5A);
        chk("add_done", done, 1);
        chk("add_pc_load", pc_load, 0);
        step();
        chk("add_idle", busy, 0);
        chk("add_done_pulse", done, 0);

        // Stray mem_ack / in_valid in IDLE ignored
        mem_ack = 1'b1; in_valid = 1'b1; mem_rdata = 8'hEE; in_data = 8'hEE;
        step();
        mem_ack = 1'b0; in_valid = 1'b0;
        $display("stray ack/valid in IDLE: busy=%0b rf_we=%0b", busy, rf_we);
        chk("stray_busy", busy, 0);
        chk("stray_rf_we", rf_we, 0);

        // LDA rd=2 from 0040, ack in third MEM cycle
        issue(16'h2A00, 8'h00, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            chk("lda_mem_req", mem_req, 1);
            chk("lda_mem_addr", mem_addr, 16'h0040);
            chk("lda_mem_we", mem_we, 0);
            chk("lda_no_wb", rf_we, 0);
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 8'hC3;
            end
            step();
        end
        mem_ack = 1'b0; mem_rdata = 8'h00;
        $display("LDA: rf_we=%0b waddr=%0d wdata=%0h mem_req=%0b", rf_we, rf_waddr, rf_wdata, mem_req);
        chk("lda_rf_we", rf_we, 1);
        chk("lda_waddr", rf_waddr, 2);
        chk("lda_wdata", rf_wdata, 8'hC3);
        chk("lda_req_drop", mem_req, 0);
        chk("lda_done", done, 1);
        step();

        // JZ taken
        issue(16'h3000, 8'h00, 16'h0123);
        $display("JZ zero: pc_load=%0b target=%0h", pc_load, pc_target);
        chk("jz_pc_load", pc_load, 1);
        chk("jz_target", pc_target, 16'h0123);
        chk("jz_rf_we", rf_we, 0);
        step();
        chk("jz_pulse", pc_load, 0);

        // JZ not taken
        issue(16'h3000, 8'h01, 16'h0123);
        $display("JZ nonzero: pc_load=%0b done=%0b", pc_load, done);
        chk("jznt_pc_load", pc_load, 0);
        chk("jznt_done", done, 1);
        step();

        // JMP
        issue(16'h3800, 8'h05, 16'hBEEF);
        $display("JMP: pc_load=%0b target=%0h", pc_load, pc_target);
        chk("jmp_pc_load", pc_load, 1);
        chk("jmp_target", pc_target, 16'hBEEF);
        step();

        // STA with a second start during MEM
        issue(16'h2000, 8'h11, 16'h0080);
        chk("sta_mem_we", mem_we, 1);
        chk("sta_wdata", mem_wdata, 8'h11);
        issue(16'h0500, 8'h22, 16'h0099);
        $display("STA after 2nd start: addr=%0h wdata=%0h", mem_addr, mem_wdata);
        chk("sta_busy", busy, 1);
        chk("sta_addr_kept", mem_addr, 16'h0080);
        chk("sta_wdata_kept", mem_wdata, 8'h11);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sta_done", done, 1);
        chk("sta_rf_we", rf_we, 0);
        step();
        chk("sta_idle", busy, 0);
        chk("sta_no_second", done, 0);

        // OUT 7E
        issue(16'h4800, 8'h7E, 16'h0000);
        $display("OUT: out_valid=%0b out_data=%0h", out_valid, out_data);
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, 8'h7E);
        chk("out_rf_we", rf_we, 0);
        step();
        chk("out_valid_pulse", out_valid, 0);
        chk("out_data_hold", out_data, 8'h7E);
        step();
        chk("out_data_hold2", out_data, 8'h7E);

        // IN rd=1, data arrives after one idle wait cycle
        issue(16'h4100, 8'h00, 16'h0000);
        chk("in_wait_busy", busy, 1);
        step();
        chk("in_wait_still", busy, 1);
        chk("in_wait_no_wb", rf_we, 0);
        in_valid = 1'b1; in_data = 8'h9D;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        $display("IN: rf_we=%0b waddr=%0d wdata=%0h", rf_we, rf_waddr, rf_wdata);
        chk("in_rf_we", rf_we, 1);
        chk("in_waddr", rf_waddr, 1);
        chk("in_wdata", rf_wdata, 8'h9D);
        step();

        // NOP opcode, with a start pulse during WB that must be dropped
        issue(16'hF800, 8'h33, 16'h0000);
        $display("NOP: done=%0b rf_we=%0b pc_load=%0b", done, rf_we, pc_load);
        chk("nop_done", done, 1);
        chk("nop_rf_we", rf_we, 0);
        issue(16'h0700, 8'h44, 16'h0000);
        chk("wb_start_idle", busy, 0);
        step();
        chk("wb_start_dropped", done, 0);

        // Reset in the middle of MEM
        issue(16'h2D00, 8'h00, 16'h0200);
        chk("rstmem_req", mem_req, 1);
        #1 rst = 1'b1;
        #1;
        $display("reset in MEM: mem_req=%0b busy=%0b", mem_req, busy);
        chk("rstmem_req_drop", mem_req, 0);
        chk("rstmem_busy", busy, 0);
        chk("rstmem_out_data", out_data, 8'h00);
        chk("rstmem_pc_load", pc_load, 0);
        mem_ack = 1'b1; mem_rdata = 8'h55;
        step();
        rst = 1'b0; mem_ack = 1'b0;
        step();
        chk("rstmem_after_busy", busy, 0);
        chk("rstmem_after_rf_we", rf_we, 0);
        chk("rstmem_after_pc", pc_load, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse from execute stage; IR/ALUOUT/Addr valid this cycle.
REQ-005 IR  in  16  instruction; IR[15:11] opcode, IR[10:8] destination register.
REQ-006 ALUOUT  in  8  execute-stage result.
REQ-007 Addr  in  16  memory/jump address.
REQ-008 mem_req, mem_we  out  1 each  memory request; mem_we=1 write, 0 read.
REQ-009 mem_addr  out  16; mem_wdata  out  8; mem_rdata  in  8; mem_ack  in  1  one-cycle completion.
REQ-010 in_data  in  8; in_valid  in  1  input-port data and qualifier.
REQ-011 rf_we  out  1; rf_waddr  out  3; rf_wdata  out  8  register-file write port.
REQ-012 pc_load  out  1; pc_target  out  16  program-counter redirect.
REQ-013 out_data  out  8 (held); out_valid  out  1 (pulse)  output port.
REQ-014 busy  out  1; done  out  1 (pulse)  stage status.

Function
REQ-015 Opcodes SHALL be ADD 00000, SUB 00001, MOV 00010, MVI 00011, STA 00100, LDA 00101, JZ 00110, JMP 00111, IN 01000, OUT 01001; all others are NOP.
REQ-016 States SHALL be IDLE, MEM, INWAIT, WB.
REQ-017 In IDLE, start SHALL latch IR, ALUOUT and Addr, and SHALL move to the next state as follows: STA/LDA to MEM; IN to INWAIT; all others to WB.
REQ-018 start SHALL be ignored while busy=1, which holds in every state except IDLE.
REQ-019 In MEM, mem_req SHALL be 1 and mem_addr SHALL equal the latched Addr. For STA, mem_we=1 and mem_wdata equals the latched ALUOUT. For LDA, mem_we=0.
REQ-020 In MEM, mem_ack SHALL capture mem_rdata (LDA) and move to WB. Without ack, the block stays in MEM indefinitely with outputs stable.
REQ-021 In INWAIT, in_valid=1 SHALL capture in_data and move to WB.
REQ-022 WB SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-023 In WB, rf_we=1 and rf_waddr=IR[10:8] SHALL apply for ADD/SUB/MOV/MVI with rf_wdata=ALUOUT, for LDA with rf_wdata=the captured mem_rdata, and for IN with rf_wdata=the captured in_data.
REQ-024 In WB, JMP SHALL assert pc_load=1 with pc_target=Addr; JZ SHALL do the same only when the latched ALUOUT==8'h00.
REQ-025 In WB, OUT SHALL load out_data with the latched ALUOUT and pulse out_valid=1; out_data then holds until the next OUT or reset.
REQ-026 Latency from start SHALL be 1 cycle to WB strobes for non-memory, non-IN ops; for memory ops it is 1 cycle after the mem_ack cycle; for IN it is 1 cycle after the in_valid cycle.
REQ-027 mem_ack asserted outside MEM and in_valid asserted outside INWAIT SHALL be ignored.
REQ-028 start arriving in the same cycle the block returns to IDLE after WB SHALL be accepted one cycle later, i.e. only in IDLE.

Reset
REQ-029 rst SHALL force IDLE and clear all latches.
REQ-030 While rst is asserted, all outputs SHALL be 0, including out_data=8'h00.
REQ-031 Reset mid-MEM SHALL drop mem_req asynchronously with no register write or pc_load.

Structure
REQ-032 Opcode constants and state encodings SHALL live in a shared package, for use also by execute and decode.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 ADD: start, IR=16'h0300 (rd=3), ALUOUT=8'h5A -> next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h5A, done=1.
REQ-035 LDA: IR=16'h2A00, Addr=16'h0040, mem_ack after 3 cycles with mem_rdata=8'hC3 -> mem_req high for 3 cycles at address 0040, then rf_waddr=2, rf_wdata=8'hC3.
REQ-036 JZ: ALUOUT=8'h00, Addr=16'h0123 -> pc_load=1 with pc_target=16'h0123. Repeated with ALUOUT=8'h01 -> pc_load stays 0, done=1.
REQ-037 STA followed by a second start while in MEM -> the second start is ignored; the write carries the first ALUOUT.
REQ-038 OUT with ALUOUT=8'h7E -> out_valid pulses once and out_data holds 8'h7E afterward.
REQ-039 rst asserted in MEM -> mem_req=0 immediately; after release busy=0 and no rf_we or pc_load has occurred.
